// File: rtl/hub75_scan_driver.sv
// HUB75 1/8-scan panel driver: shifts each scan row out of a synchronous-read
// frame buffer, then blanks, latches and displays it for a fixed on-time.
module hub75_scan_driver #(
    parameter int COLS         = 32,
    parameter int COL_BITS     = 5,
    parameter int CLK_DIV      = 2,
    parameter int BLANK_CYCLES = 4,
    parameter int ON_CYCLES    = 64
) (
    input  logic                  i_clkin,
    input  logic                  i_rst,
    input  logic                  i_enable,
    output logic [3+COL_BITS-1:0] o_addr,
    input  logic [5:0]            i_data,
    output logic                  o_r1,
    output logic                  o_g1,
    output logic                  o_b1,
    output logic                  o_r2,
    output logic                  o_g2,
    output logic                  o_b2,
    output logic                  o_clk,
    output logic                  o_lat,
    output logic                  o_a,
    output logic                  o_b,
    output logic                  o_c,
    output logic                  o_oe,
    output logic                  o_frame_done
);

    // state | meaning
    // IDLE  | panel blanked, waiting for enable
    // SHIFT | one 2*CLK_DIV slot per column, panel clock high in second half
    // BLANK | Oe high, row select updated
    // LATCH | Lat high for two cycles
    // HOLD  | Oe low for the on-time, row advances on the last cycle
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_BLANK = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam int PH_W  = $clog2(2*CLK_DIV);
    localparam int CNT_W = 16;

    localparam logic [PH_W-1:0]     PH_LAST    = PH_W'(2*CLK_DIV-1);
    localparam logic [PH_W-1:0]     PH_RISE    = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0]     PH_DATA    = PH_W'(1);
    localparam logic [COL_BITS-1:0] COL_LAST   = COL_BITS'(COLS-1);
    localparam logic [CNT_W-1:0]    BLANK_LOAD = CNT_W'(BLANK_CYCLES-1);
    localparam logic [CNT_W-1:0]    LATCH_LOAD = CNT_W'(1);
    localparam logic [CNT_W-1:0]    ON_LOAD    = CNT_W'(ON_CYCLES-1);

    logic [2:0]          r_state;
    logic [PH_W-1:0]     r_ph;
    logic [COL_BITS-1:0] r_col;
    logic [2:0]          r_row;
    logic [2:0]          r_rowsel;
    logic [CNT_W-1:0]    r_cnt;
    logic [5:0]          r_rgb;
    logic                r_oe;

    logic       w_tc;
    logic       w_slot_end;
    logic       w_data_slot;
    logic       w_row_end;
    logic [5:0] w_rgb;

    assign w_tc        = (r_cnt == '0);
    assign w_slot_end  = (r_ph == PH_LAST);
    assign w_data_slot = (r_state == S_SHIFT) && (r_ph == PH_DATA);
    assign w_row_end   = (r_state == S_HOLD) && w_tc;

    // RAM data reaches the pins in the cycle it arrives so it is stable
    // CLK_DIV-1 cycles ahead of the panel clock rising edge.
    assign w_rgb = w_data_slot ? i_data : r_rgb;

    always_ff @(posedge i_clkin) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_ph     <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_rowsel <= '0;
            r_cnt    <= '0;
            r_rgb    <= '0;
            r_oe     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_state <= S_SHIFT;
                        r_ph    <= '0;
                        r_col   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_data_slot)
                        r_rgb <= i_data;
                    if (w_slot_end) begin
                        r_ph  <= '0;
                        r_col <= r_col + 1'b1;
                        if (r_col == COL_LAST) begin
                            r_state  <= S_BLANK;
                            r_cnt    <= BLANK_LOAD;
                            r_rowsel <= r_row;
                            r_oe     <= 1'b1;
                        end
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                S_BLANK: begin
                    if (w_tc) begin
                        r_state <= S_LATCH;
                        r_cnt   <= LATCH_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_LATCH: begin
                    if (w_tc) begin
                        r_state <= S_HOLD;
                        r_cnt   <= ON_LOAD;
                        r_oe    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_tc) begin
                        r_row <= r_row + 1'b1;
                        if (i_enable) begin
                            r_state <= S_SHIFT;
                            r_ph    <= '0;
                            r_col   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_oe    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_addr = {r_row, r_col};
    assign {o_r1, o_g1, o_b1, o_r2, o_g2, o_b2} = w_rgb;
    assign o_clk        = (r_state == S_SHIFT) && (r_ph >= PH_RISE);
    assign o_lat        = (r_state == S_LATCH);
    assign {o_c, o_b, o_a} = r_rowsel;
    assign o_oe         = r_oe;
    assign o_frame_done = w_row_end && (r_row == 3'd7);

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: default instance plus a CLK_DIV=3, COLS=8
// instance, both checked each cycle against a row-timeline model.
module tb_hub75_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, en0 = 1'b0, rst1 = 1'b1, en1 = 1'b0;
    logic [7:0] addr0;
    logic [5:0] addr1;
    logic [5:0] data0 = '0, data1 = '0;
    logic [5:0] rgb0, rgb1;
    logic clk0, lat0, oe0, fd0, clk1, lat1, oe1, fd1;
    logic [2:0] abc0, abc1;

    hub75_scan_driver u_dut0 (
        .i_clkin(clk), .i_rst(rst0), .i_enable(en0), .o_addr(addr0), .i_data(data0),
        .o_r1(rgb0[5]), .o_g1(rgb0[4]), .o_b1(rgb0[3]), .o_r2(rgb0[2]), .o_g2(rgb0[1]), .o_b2(rgb0[0]),
        .o_clk(clk0), .o_lat(lat0), .o_a(abc0[0]), .o_b(abc0[1]), .o_c(abc0[2]),
        .o_oe(oe0), .o_frame_done(fd0));

    hub75_scan_driver #(.COLS(8), .COL_BITS(3), .CLK_DIV(3), .BLANK_CYCLES(4), .ON_CYCLES(64)) u_dut1 (
        .i_clkin(clk), .i_rst(rst1), .i_enable(en1), .o_addr(addr1), .i_data(data1),
        .o_r1(rgb1[5]), .o_g1(rgb1[4]), .o_b1(rgb1[3]), .o_r2(rgb1[2]), .o_g2(rgb1[1]), .o_b2(rgb1[0]),
        .o_clk(clk1), .o_lat(lat1), .o_a(abc1[0]), .o_b(abc1[1]), .o_c(abc1[2]),
        .o_oe(oe1), .o_frame_done(fd1));

    // synchronous-read frame buffers holding Data = Addr[5:0]
    always @(posedge clk) begin
        data0 <= addr0[5:0];
        data1 <= addr1;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int i, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, i, cyc, got, want);
        end
    endtask

    // row timeline model: offset t within the row period, per instance
    int CDv[2]   = '{2, 3};
    int COLSv[2] = '{32, 8};
    bit m_act[2] = '{0, 0};
    bit m_soe[2] = '{1, 1};
    int m_t[2]   = '{0, 0};
    int m_row[2] = '{0, 0};
    int m_abc[2] = '{0, 0};
    int m_last[2] = '{0, 0};

    function automatic int ramf(input int i, input int row, input int col);
        return (row * COLSv[i] + col) % 64;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit r, e;
            int s, p;
            r = (i == 0) ? rst0 : rst1;
            e = (i == 0) ? en0 : en1;
            s = 2 * CDv[i] * COLSv[i];
            p = s + 4 + 2 + 64;
            if (r) begin
                m_act[i] = 0; m_row[i] = 0; m_abc[i] = 0; m_last[i] = 0; m_t[i] = 0;
            end else if (!m_act[i]) begin
                if (e) begin m_act[i] = 1; m_t[i] = 0; m_soe[i] = 1; end
            end else begin
                if (m_t[i] == s - 1) begin
                    m_last[i] = ramf(i, m_row[i], COLSv[i] - 1);
                    m_abc[i] = m_row[i];
                end
                m_t[i]++;
                if (m_t[i] == p) begin
                    m_row[i] = (m_row[i] + 1) % 8;
                    if (e) begin m_t[i] = 0; m_soe[i] = 0; end
                    else m_act[i] = 0;
                end
            end
        end
    end

    int q_rise0[$], q_rise1[$], q_lat0[$], q_lat1[$], q_fd0[$], q_abc0[$], q_hi1[$];
    logic [5:0] q_rgb0[$];
    bit pclk[2] = '{0, 0};
    bit plat[2] = '{0, 0};
    int hirun = 0;
    int oelow0 = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                int s, p, t, col, ph, eclk, elat, eoe, efd, ergb, eaddr, addr_chk;
                bit o_clk, o_lat, o_oe, o_fd;
                int o_rgb, o_abc, o_addr;
                o_clk = (i == 0) ? clk0 : clk1;
                o_lat = (i == 0) ? lat0 : lat1;
                o_oe  = (i == 0) ? oe0 : oe1;
                o_fd  = (i == 0) ? fd0 : fd1;
                o_rgb = (i == 0) ? int'(rgb0) : int'(rgb1);
                o_abc = (i == 0) ? int'(abc0) : int'(abc1);
                o_addr = (i == 0) ? int'(addr0) : int'(addr1);
                s = 2 * CDv[i] * COLSv[i];
                p = s + 4 + 2 + 64;
                t = m_t[i];
                eclk = 0; elat = 0; eoe = 1; efd = 0; ergb = m_last[i];
                eaddr = 0; addr_chk = 0;
                if (!m_act[i]) begin
                    addr_chk = (m_row[i] == 0);
                end else if (t < s) begin
                    col = t / (2 * CDv[i]);
                    ph = t % (2 * CDv[i]);
                    eclk = (ph >= CDv[i]);
                    eoe = m_soe[i];
                    if (ph != 0) ergb = ramf(i, m_row[i], col);
                    else if (col > 0) ergb = ramf(i, m_row[i], col - 1);
                    if (ph == 0) begin addr_chk = 1; eaddr = m_row[i] * COLSv[i] + col; end
                end else if (t < s + 4) begin
                    eoe = 1;
                end else if (t < s + 6) begin
                    elat = 1;
                end else begin
                    eoe = 0;
                    efd = (t == p - 1) && (m_row[i] == 7);
                end
                chk("clk", i, int'(o_clk), eclk);
                chk("lat", i, int'(o_lat), elat);
                chk("oe", i, int'(o_oe), eoe);
                chk("frame_done", i, int'(o_fd), efd);
                chk("rgb", i, o_rgb, ergb);
                chk("abc", i, o_abc, m_abc[i]);
                if (addr_chk) chk("addr", i, o_addr, eaddr);

                if (o_clk && !pclk[i]) begin
                    if (i == 0) begin q_rise0.push_back(cyc); q_rgb0.push_back(rgb0); end
                    else q_rise1.push_back(cyc);
                end
                if (o_lat && !plat[i]) begin
                    if (i == 0) begin q_lat0.push_back(cyc); q_abc0.push_back(int'(abc0)); end
                    else q_lat1.push_back(cyc);
                end
                if (i == 0 && o_fd) q_fd0.push_back(cyc);
                if (i == 0 && !o_oe) oelow0++;
                if (i == 1) begin
                    if (o_clk) hirun++;
                    else begin
                        if (pclk[1]) q_hi1.push_back(hirun);
                        hirun = 0;
                    end
                end
                pclk[i] = o_clk;
                plat[i] = o_lat;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step(1);
    endtask

    int e0, e1, n2, n3, good;

    initial begin
        step(2);
        chk_on = 1'b1;
        rst0 = 1'b0; rst1 = 1'b0; en1 = 1'b1;
        e1 = cyc + 1;

        // idle after reset
        step(50);
        chk("idle_oe", 0, int'(oe0), 1);
        chk("idle_addr", 0, int'(addr0), 0);
        chk("idle_no_clk", 0, q_rise0.size(), 0);

        // first row from IDLE
        en0 = 1'b1;
        e0 = cyc + 1;
        wait_until(e0 + 197);
        chk("row0_rises", 0, q_rise0.size(), 32);
        chk("first_rise", 0, (q_rise0.size() > 0) ? q_rise0[0] - e0 : -1, 2);
        good = 0;
        for (int k = 1; k < q_rise0.size(); k++) if (q_rise0[k] - q_rise0[k-1] == 4) good++;
        chk("rise_spacing", 0, good, 31);
        chk("col5_rgb", 0, (q_rgb0.size() > 5) ? int'(q_rgb0[5]) : -1, 5);
        chk("lat_start", 0, (q_lat0.size() > 0) ? q_lat0[0] - e0 : -1, 132);
        chk("oe_low_cycles", 0, oelow0, 64);

        // two full frames
        wait_until(e0 + 3169);
        chk("fd_count", 0, q_fd0.size(), 2);
        chk("fd_first", 0, (q_fd0.size() > 0) ? q_fd0[0] - e0 : -1, 1583);
        chk("fd_period", 0, (q_fd0.size() > 1) ? q_fd0[1] - q_fd0[0] : -1, 1584);
        good = 0;
        for (int k = 1; k < q_lat0.size(); k++) if (q_lat0[k] - q_lat0[k-1] == 198) good++;
        chk("row_period", 0, good, 15);
        good = 0;
        for (int k = 0; k < q_abc0.size(); k++) if (q_abc0[k] == k % 8) good++;
        chk("row_sequence", 0, good, 16);

        // enable dropped at col 10 of row 3
        wait_until(e0 + 19 * 198 + 40);
        en0 = 1'b0;
        wait_until(e0 + 20 * 198 + 15);
        chk("drop_oe", 0, int'(oe0), 1);
        chk("drop_abc", 0, int'(abc0), 3);
        chk("drop_clk", 0, int'(clk0), 0);
        en0 = 1'b1;
        n2 = cyc;
        step(1);
        chk("resume_addr", 0, int'(addr0), 8'h80);

        // reset on the first latch cycle
        wait_until(n2 + 1 + 132);
        chk("pre_rst_lat", 0, int'(lat0), 1);
        rst0 = 1'b1; en0 = 1'b0;
        step(1);
        rst0 = 1'b0;
        chk("rst_lat", 0, int'(lat0), 0);
        chk("rst_oe", 0, int'(oe0), 1);
        chk("rst_abc", 0, int'(abc0), 0);
        chk("rst_addr", 0, int'(addr0), 0);
        step(5);
        en0 = 1'b1;
        n3 = cyc;
        step(1);
        chk("restart_addr", 0, int'(addr0), 0);
        wait_until(n3 + 1 + 198);
        chk("restart_row1", 0, int'(addr0), 8'h20);

        // CLK_DIV=3, COLS=8 instance
        chk("d1_first_rise", 1, (q_rise1.size() > 0) ? q_rise1[0] - e1 : -1, 3);
        good = 0;
        for (int k = 0; k < q_rise1.size(); k++) if (q_rise1[k] < e1 + 48) good++;
        chk("d1_row_rises", 1, good, 8);
        good = 0;
        for (int k = 1; k < 8 && k < q_rise1.size(); k++) if (q_rise1[k] - q_rise1[k-1] == 6) good++;
        chk("d1_clk_period", 1, good, 7);
        good = 0;
        for (int k = 0; k < 8 && k < q_hi1.size(); k++) if (q_hi1[k] == 3) good++;
        chk("d1_clk_high", 1, good, 8);
        chk("d1_lat_start", 1, (q_lat1.size() > 0) ? q_lat1[0] - e1 : -1, 52);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
